// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler sharing one egress consumer between NQ FIFO controllers.
// Issues burst reads under backpressure and serialises flush requests into one-cycle pulses.
module fifo_rr_sched #(
    parameter int NQ    = 4,
    parameter int QW    = 2,
    parameter int BURST = 4,
    parameter int BW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [NQ-1:0] notempty,
    input  logic [NQ-1:0] flsh_req,
    input  logic          out_rdy,
    output logic [NQ-1:0] fiford,
    output logic [NQ-1:0] fifoflsh,
    output logic [NQ-1:0] flsh_done,
    output logic          out_vld,
    output logic [QW-1:0] out_qid,
    output logic          gnt_vld,
    output logic [QW-1:0] gnt_qid
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH} state_e;

    state_e        state_q;
    logic [QW-1:0] gq_q;
    logic [QW-1:0] rr_q;
    logic [QW-1:0] fq_q;
    logic [BW-1:0] bcnt_q;
    logic          out_vld_q;
    logic [QW-1:0] out_qid_q;

    logic          rd;
    logic          stop;
    logic          any_flsh;
    logic          pick_vld;
    logic [QW-1:0] pick_q;
    logic [QW-1:0] flsh_q;
    logic [QW-1:0] idx;
    logic [BW-1:0] bcnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pick_vld = 1'b0;
        pick_q   = '0;
        idx      = '0;
        // Scan downwards so the candidate closest to rr+1 is the last one written and wins.
        for (int k = NQ; k >= 1; k--) begin
            idx = QW'((int'(rr_q) + k) % NQ);
            if (notempty[idx] && !flsh_req[idx]) begin
                pick_vld = 1'b1;
                pick_q   = idx;
            end
        end
        flsh_q = '0;
        for (int i = NQ - 1; i >= 0; i--) begin
            if (flsh_req[i]) flsh_q = QW'(i);
        end
        any_flsh = |flsh_req;
    end

    always_comb begin
        stop   = !en || !notempty[gq_q] || flsh_req[gq_q];
        rd     = (state_q == S_BURST) && en && out_rdy && notempty[gq_q] && !flsh_req[gq_q];
        bcnt_d = bcnt_q + 1'b1;

        fiford         = '0;
        fiford[gq_q]   = rd;
        fifoflsh       = '0;
        fifoflsh[fq_q] = (state_q == S_FLUSH);
        flsh_done      = fifoflsh;
        gnt_vld        = (state_q == S_BURST);
        gnt_qid        = gnt_vld ? gq_q : '0;
    end

    assign out_vld = out_vld_q;
    assign out_qid = out_qid_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gq_q      <= '0;
            rr_q      <= QW'(NQ - 1);
            fq_q      <= '0;
            bcnt_q    <= '0;
            out_vld_q <= 1'b0;
            out_qid_q <= '0;
        end else begin
            out_vld_q <= rd;
            out_qid_q <= gq_q;
            case (state_q)
                S_IDLE: begin
                    if (any_flsh) begin
                        state_q <= S_FLUSH;
                        fq_q    <= flsh_q;
                    end else if (en && pick_vld) begin
                        state_q <= S_BURST;
                        gq_q    <= pick_q;
                        bcnt_q  <= '0;
                    end
                end
                S_BURST: begin
                    // Neither stop nor rd means out_rdy is low: hold the grant.
                    if (stop) begin
                        state_q <= S_IDLE;
                        rr_q    <= gq_q;
                    end else if (rd) begin
                        bcnt_q <= bcnt_d;
                        if (bcnt_d == BW'(BURST)) begin
                            state_q <= S_IDLE;
                            rr_q    <= gq_q;
                        end
                    end
                end
                S_FLUSH: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Self-checking bench for fifo_rr_sched: per-cycle vector table plus hand-written corner sequences,
// with a scoreboard matching every read strobe to the out_vld/out_qid one cycle later.
module tb_fifo_rr_sched;

    localparam int NQ = 4;
    localparam int QW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [NQ-1:0] notempty;
    logic [NQ-1:0] flsh_req;
    logic          out_rdy;
    logic [NQ-1:0] fiford;
    logic [NQ-1:0] fifoflsh;
    logic [NQ-1:0] flsh_done;
    logic          out_vld;
    logic [QW-1:0] out_qid;
    logic          gnt_vld;
    logic [QW-1:0] gnt_qid;

    fifo_rr_sched #(.NQ(NQ), .QW(QW), .BURST(4), .BW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .notempty (notempty),
        .flsh_req (flsh_req),
        .out_rdy  (out_rdy),
        .fiford   (fiford),
        .fifoflsh (fifoflsh),
        .flsh_done(flsh_done),
        .out_vld  (out_vld),
        .out_qid  (out_qid),
        .gnt_vld  (gnt_vld),
        .gnt_qid  (gnt_qid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit          rst;
        bit          en;
        logic [3:0]  ne;
        logic [3:0]  fr;
        bit          rdy;
        logic [3:0]  rd;
        logic [3:0]  fl;
        bit          gv;
        logic [1:0]  gq;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         sb[$];
    vec_t       tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit rst, bit e, logic [3:0] ne, logic [3:0] fr, bit rdy,
                                logic [3:0] rd, logic [3:0] fl, bit gv, logic [1:0] gq);
        vec_t v;
        v.rst = rst; v.en = e; v.ne = ne; v.fr = fr; v.rdy = rdy;
        v.rd = rd; v.fl = fl; v.gv = gv; v.gq = gq;
        return v;
    endfunction

    // Drive one cycle's inputs just after the rising edge, compare at the falling edge.
    task automatic apply(input vec_t v, input string tag);
        rst_n    = !v.rst;
        en       = v.en;
        notempty = v.ne;
        flsh_req = v.fr;
        out_rdy  = v.rdy;
        @(negedge clk);
        check({tag, ".fiford"}, 32'(fiford), 32'(v.rd));
        check({tag, ".fifoflsh"}, 32'(fifoflsh), 32'(v.fl));
        check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(v.gv));
        check({tag, ".gnt_qid"}, 32'(gnt_qid), 32'(v.gq));
        if (v.rst) begin
            check({tag, ".rst_out_vld"}, 32'(out_vld), 32'd0);
            check({tag, ".rst_out_qid"}, 32'(out_qid), 32'd0);
            check({tag, ".rst_flsh_done"}, 32'(flsh_done), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add_burst(input logic [3:0] ne, input int q);
        logic [3:0] oh;
        oh = 4'b0001 << q;
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 1, ne, 4'b0, 1, oh, 4'b0, 1, 2'(q)));
    endtask

    // Scoreboard: each read strobe predicts out_vld with that queue id one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_vld) begin
                if (sb.size() == 0) check("sb_unexpected_out_vld", 32'd1, 32'd0);
                else check("sb_out_qid", 32'(out_qid), 32'(sb.pop_front()));
            end
            check("mon_rd_flsh_overlap", 32'(fiford & fifoflsh), 32'd0);
            check("mon_fiford_onehot0", 32'($countones(fiford) <= 1), 32'd1);
            check("mon_flsh_done_eq", 32'(flsh_done), 32'(fifoflsh));
            for (int i = 0; i < NQ; i++) if (fiford[i]) sb.push_back(i);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; notempty = '0; flsh_req = '0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single active queue: two bursts of four with one bubble.
        tbl.push_back(mk(1, 1, 4'b0001, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));
        add_burst(4'b0001, 0);
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));
        add_burst(4'b0001, 0);
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));
        // All queues busy after reset: grant order 0,1,2,3,0.
        tbl.push_back(mk(1, 1, 4'b1111, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));
        for (int g = 0; g < 5; g++) begin
            tbl.push_back(mk(0, 1, 4'b1111, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));
            add_burst(4'b1111, g % 4);
        end
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));
        // en low blocks new grants.
        tbl.push_back(mk(0, 0, 4'b1111, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0, 1, 4'b0, 4'b0, 0, 2'd0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Queue 2 empties after two reads; next grant goes to queue 3. rr is 0 here.
        apply(mk(0, 1, 4'b0100, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "drop_idle");
        apply(mk(0, 1, 4'b1100, 4'b0, 1, 4'b0100, 4'b0, 1, 2'd2), "drop_rd1");
        apply(mk(0, 1, 4'b1100, 4'b0, 1, 4'b0100, 4'b0, 1, 2'd2), "drop_rd2");
        apply(mk(0, 1, 4'b1000, 4'b0, 1, 4'b0000, 4'b0, 1, 2'd2), "drop_exit");
        apply(mk(0, 1, 4'b1000, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "drop_bubble");
        apply(mk(0, 1, 4'b1000, 4'b0, 1, 4'b1000, 4'b0, 1, 2'd3), "drop_q3");
        apply(mk(0, 1, 4'b0000, 4'b0, 1, 4'b0000, 4'b0, 1, 2'd3), "drop_q3_exit");
        apply(mk(0, 1, 4'b0000, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "drop_end");

        // Backpressure on queue 1: out_rdy 1,0,0,1,1,1.
        apply(mk(0, 1, 4'b0010, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "bp_idle");
        apply(mk(0, 1, 4'b0010, 4'b0, 1, 4'b0010, 4'b0, 1, 2'd1), "bp_rd1");
        apply(mk(0, 1, 4'b0010, 4'b0, 0, 4'b0000, 4'b0, 1, 2'd1), "bp_hold1");
        apply(mk(0, 1, 4'b0010, 4'b0, 0, 4'b0000, 4'b0, 1, 2'd1), "bp_hold2");
        apply(mk(0, 1, 4'b0010, 4'b0, 1, 4'b0010, 4'b0, 1, 2'd1), "bp_rd2");
        apply(mk(0, 1, 4'b0010, 4'b0, 1, 4'b0010, 4'b0, 1, 2'd1), "bp_rd3");
        apply(mk(0, 1, 4'b0010, 4'b0, 1, 4'b0010, 4'b0, 1, 2'd1), "bp_rd4");
        apply(mk(0, 1, 4'b0000, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "bp_end");

        // Flush of the granted queue mid-burst: read stops at once, pulse two cycles later.
        apply(mk(0, 1, 4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd0), "fg_idle");
        apply(mk(0, 1, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 1, 2'd1), "fg_rd1");
        apply(mk(0, 1, 4'b0010, 4'b0010, 1, 4'b0000, 4'b0000, 1, 2'd1), "fg_stop");
        apply(mk(0, 1, 4'b0010, 4'b0010, 1, 4'b0000, 4'b0000, 0, 2'd0), "fg_idle2");
        apply(mk(0, 1, 4'b0010, 4'b0010, 1, 4'b0000, 4'b0010, 0, 2'd0), "fg_flush");
        apply(mk(0, 1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd0), "fg_after");

        // Two flush requests in IDLE, lowest first, each beating a pending grant.
        apply(mk(0, 1, 4'b0001, 4'b1010, 1, 4'b0000, 4'b0000, 0, 2'd0), "ff_idle");
        apply(mk(0, 1, 4'b0001, 4'b1010, 1, 4'b0000, 4'b0010, 0, 2'd0), "ff_q1");
        apply(mk(0, 1, 4'b0001, 4'b1000, 1, 4'b0000, 4'b0000, 0, 2'd0), "ff_gap");
        apply(mk(0, 1, 4'b0000, 4'b1000, 1, 4'b0000, 4'b1000, 0, 2'd0), "ff_q3");
        apply(mk(0, 1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd0), "ff_end");

        // Reset mid-burst: outputs drop without a clock edge, first grant afterwards is queue 0.
        apply(mk(0, 1, 4'b0100, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "rs_idle");
        apply(mk(0, 1, 4'b0100, 4'b0, 1, 4'b0100, 4'b0, 1, 2'd2), "rs_rd1");
        apply(mk(0, 1, 4'b0100, 4'b0, 1, 4'b0100, 4'b0, 1, 2'd2), "rs_rd2");
        rst_n = 1'b0;
        #1;
        check("rs_async_fiford", 32'(fiford), 32'd0);
        check("rs_async_gnt_vld", 32'(gnt_vld), 32'd0);
        check("rs_async_out_vld", 32'(out_vld), 32'd0);
        apply(mk(1, 1, 4'b1111, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "rs_held");
        apply(mk(0, 1, 4'b1111, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "rs_release");
        for (int k = 0; k < 4; k++)
            apply(mk(0, 1, 4'b1111, 4'b0, 1, 4'b0001, 4'b0, 1, 2'd0), $sformatf("rs_q0_%0d", k));
        apply(mk(0, 1, 4'b0000, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "rs_end");
        apply(mk(0, 1, 4'b0000, 4'b0, 1, 4'b0000, 4'b0, 0, 2'd0), "drain");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
